// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, state enum and default operand width shared by muldiv_seq
package muldiv_pkg;
    localparam int MULDIV_WIDTH = 32;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;
    typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_seq_div_step.sv
// div_step: one combinational restoring-division step on a shifted partial remainder
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] diff;
    assign diff     = rem - {1'b0, dvsr};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    state_t             state;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   rs_r, rt_r, sh, m;
    logic [2*WIDTH-1:0] acc, prod;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, is_div, is_signed, sa, sb, q_bit;
    logic [WIDTH-1:0]   mag_a, mag_b, rem_next, res_hi;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a, ext_b;
    assign ext_a = {{WIDTH{sa}}, rs_r};
    assign ext_b = {{WIDTH{sb}}, rt_r};
`endif
    assign busy = (state != IDLE);
    always_comb begin
        is_div    = (op_r == OP_DIV) || (op_r == OP_DIVU);
        is_signed = (op_r == OP_MULT) || (op_r == OP_DIV);
        sa        = is_signed & rs_r[WIDTH-1];
        sb        = is_signed & rt_r[WIDTH-1];
        mag_a     = sa ? -rs_r : rs_r;
        mag_b     = sb ? -rt_r : rt_r;
        prod      = neg_q ? -acc : acc;
        res_hi    = is_div ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    end
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      ({acc[2*WIDTH-1:WIDTH], sh[WIDTH-1]}),
        .dvsr     (m),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) state <= IDLE;
            else case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        op_r  <= op;
                        rs_r  <= rs;
                        rt_r  <= rt;
                        state <= PREP;
                    end
                end
                PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    sh    <= is_div ? mag_a : mag_b;
                    m     <= is_div ? mag_b : mag_a;
                    acc   <= '0;
                    cnt   <= CW'(WIDTH - 1);
                    state <= CALC;
                    if (is_div && rt_r == '0) begin
                        lo    <= '1;
                        hi    <= rs_r;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!is_div) begin
                        {hi, lo} <= ext_a * ext_b;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
`endif
                end
                CALC: begin
                    acc <= is_div ? {rem_next, acc[WIDTH-2:0], q_bit}
                                  : {acc[2*WIDTH-2:0], 1'b0} + (sh[WIDTH-1] ? {{WIDTH{1'b0}}, m} : '0);
                    sh  <= sh << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= prod[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against a cycle-timeline reference model
module tb_muldiv_seq;
    logic        clk = 0, rst_n = 0, start = 0, flush = 0, mthi = 0, mtlo = 0;
    logic [1:0]  op = 0;
    logic [31:0] rs = 0, rt = 0, wdata = 0, hi, lo;
    logic        busy, done;
    int          checks = 0, errors = 0, cyc = 0;
    bit          chk = 0;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 35;
`endif

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {hi, lo} an op must produce, from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (o[1] && b == 0) return {a, 32'hFFFF_FFFF};
        case (o)
            2'd0:    return sa * sb;
            2'd1:    return ua * ub;
            2'd2:    return {32'(sa % sb), 32'(sa / sb)};
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] b);
        if (o[1] && b == 0) return 2;
        return o[1] ? 35 : MUL_LAT;
    endfunction

    int          m_rem = 0;
    logic [31:0] e_hi = 0, e_lo = 0, p_hi = 0, p_lo = 0;
    logic        e_done = 0;

    always @(posedge clk) begin
        e_done = 0;
        if (!rst_n) begin
            m_rem = 0;
            e_hi  = 0;
            e_lo  = 0;
        end else if (flush) m_rem = 0;
        else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                e_hi   = p_hi;
                e_lo   = p_lo;
                e_done = 1;
            end
        end else begin
            if (mthi) e_hi = wdata;
            if (mtlo) e_lo = wdata;
            if (start) begin
                {p_hi, p_lo} = ref_res(op, rs, rt);
                m_rem = latency(op, rt) - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk) begin
            check($sformatf("busy@%0d", cyc), 64'(busy), 64'(m_rem > 0));
            check($sformatf("done@%0d", cyc), 64'(done), 64'(e_done));
            check($sformatf("hi@%0d", cyc), 64'(hi), 64'(e_hi));
            check($sformatf("lo@%0d", cyc), 64'(lo), 64'(e_lo));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int lat, input string nm);
        int  t0;
        bit  got;
        @(negedge clk);
        start = 1; op = o; rs = a; rt = b; t0 = cyc;
        @(negedge clk);
        start = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                check({nm, "_lat"}, 64'(cyc - t0), 64'(lat));
                check({nm, "_hi"}, 64'(hi), 64'(eh));
                check({nm, "_lo"}, 64'(lo), 64'(el));
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within 100 cycles, expected at %0d", nm, lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        check("pin_model_mult", ref_res(2'd0, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
        check("pin_model_div", ref_res(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1;
        chk = 1;

        run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, "mult");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, "multu");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, "div");
        run_op(2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 35, "divu");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 35, "div_ovf");
        run_op(2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, "div0");

        @(negedge clk);
        mthi = 1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 0; start = 1; op = 2'd0; rs = 32'd3; rt = 32'd5; t0 = cyc;
        @(negedge clk);
        start = 0;
        while (cyc < t0 + 5) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        while (cyc < t0 + 10) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), (MUL_LAT == 2) ? 64'd0 : 64'h1234);

        @(negedge clk);
        start = 1; op = 2'd2; rs = 32'd100; rt = 32'd7;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);

        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int i = 0; i < 50 && m_rem > 0; i++) @(negedge clk);
            op = 2'($urandom_range(0, 3));
            rs = $urandom;
            rt = $urandom;
            case ($urandom_range(0, 7))
                0: rt = 32'd0;
                1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
                2: rt = 32'($urandom_range(1, 15));
                default: ;
            endcase
            wdata = $urandom;
            flush = ($urandom_range(0, 15) == 0);
            mthi  = !flush && ($urandom_range(0, 3) == 0);
            mtlo  = !flush && ($urandom_range(0, 3) == 0);
            start = 1;
            @(negedge clk);
            start = 0; mthi = 0; mtlo = 0; flush = 0;
            for (int i = 0; i < 50 && m_rem > 0; i++) begin
                flush = ($urandom_range(0, 40) == 0);
                mthi  = ($urandom_range(0, 7) == 0);
                start = ($urandom_range(0, 15) == 0);
                wdata = $urandom;
                @(negedge clk);
            end
            flush = 0; mthi = 0; start = 0;
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
